// File: rtl/retire_store_buffer_pkg.sv
// retire_store_buffer_pkg: shared bus encodings, entry type and helpers for the retire store buffer.
// Rev 1.0
`default_nettype none

package retire_store_buffer_pkg;

  localparam int XLEN             = 32;
  localparam int SB_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_command_t;

  typedef enum logic [1:0] {
    BYTE   = 2'h0,
    HALF   = 2'h1,
    WORD   = 2'h2,
    DOUBLE = 2'h3
  } mem_size_t;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] addr;
    logic [63:0]     data;
  } sb_entry_t;

  function automatic logic same_dword(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return a[XLEN-1:3] == b[XLEN-1:3];
  endfunction

endpackage

`default_nettype wire

// File: rtl/retire_store_buffer_fwd.sv
// store_buffer_fwd: youngest-first dword match over buffered entries and the incoming store.
// Rev 1.0
`default_nettype none

module store_buffer_fwd
  import retire_store_buffer_pkg::*;
#(
  parameter  int SB_DEPTH = SB_DEPTH_DEFAULT,
  localparam int PW       = $clog2(SB_DEPTH)
) (
  input  sb_entry_t        entries [SB_DEPTH],
  input  logic [PW-1:0]    head,
  input  logic             store_en,
  input  logic [XLEN-1:0]  store_addr,
  input  logic [63:0]      store_data,
  input  logic [XLEN-1:0]  ld_addr,
  output logic             hit,
  output logic [63:0]      data
);

  logic [PW-1:0] idx;

  // Walk oldest to youngest so a later (younger) match overrides an earlier one.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx = head + PW'(i);
      if (entries[idx].valid && same_dword(entries[idx].addr, ld_addr)) begin
        hit  = 1'b1;
        data = entries[idx].data;
      end
    end
    if (store_en && same_dword(store_addr, ld_addr)) begin
      hit  = 1'b1;
      data = store_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/retire_store_buffer.sv
// retire_store_buffer: in-order committed-store FIFO that drains to data memory and forwards to loads.
// Rev 1.0
`default_nettype none

module retire_store_buffer
  import retire_store_buffer_pkg::*;
#(
  parameter  int SB_DEPTH        = SB_DEPTH_DEFAULT,
  parameter  bit OVERFLOW_ASSERT = 1'b1,
  localparam int PW              = $clog2(SB_DEPTH),
  localparam int CW              = PW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             store_en,
  input  logic [XLEN-1:0]  store_addr,
  input  logic [63:0]      store_data,
  input  logic [3:0]       mem2proc_response,
  output bus_command_t     proc2Dmem_command,
  output logic [XLEN-1:0]  proc2Dmem_addr,
  output logic [63:0]      proc2Dmem_data,
  output mem_size_t        proc2Dmem_size,
  input  logic [XLEN-1:0]  ld_addr,
  output logic             ld_hit,
  output logic [63:0]      ld_data,
  output logic [CW-1:0]    sb_count,
  output logic             sb_empty,
  output logic             sb_almost_full,
  output logic             sb_overflow
);

  sb_entry_t     entries [SB_DEPTH];
  logic [CW-1:0] head, tail, count;
  logic [PW-1:0] head_idx, tail_idx, young_idx;
  logic          head_valid, full, pop, coalesce, push, drop;

  assign head_idx   = head[PW-1:0];
  assign tail_idx   = tail[PW-1:0];
  assign young_idx  = tail_idx - PW'(1);
  assign count      = tail - head;
  assign head_valid = (count != '0);
  assign full       = (count == CW'(SB_DEPTH));
  assign pop        = head_valid && (mem2proc_response != 4'h0);

  // Rewriting the head is harmless until memory accepts it; only an accepted head must stay intact.
  assign coalesce = store_en && head_valid
                 && same_dword(entries[young_idx].addr, store_addr)
                 && !((young_idx == head_idx) && pop);
  assign push     = store_en && !coalesce && (!full || pop);
  assign drop     = store_en && !coalesce && full && !pop;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head        <= '0;
      tail        <= '0;
      sb_overflow <= 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) entries[i] <= '0;
    end else begin
      if (pop) begin
        entries[head_idx].valid <= 1'b0;
        head                    <= head + CW'(1);
      end
      if (coalesce) entries[young_idx].data <= store_data;
      // When full, push and pop share a slot; the push is written last so it wins.
      if (push) begin
        entries[tail_idx] <= '{valid: 1'b1, addr: {store_addr[XLEN-1:3], 3'b000}, data: store_data};
        tail              <= tail + CW'(1);
      end
      if (drop) sb_overflow <= 1'b1;
    end
  end

  assign proc2Dmem_command = head_valid ? BUS_STORE : BUS_NONE;
  assign proc2Dmem_addr    = head_valid ? entries[head_idx].addr : '0;
  assign proc2Dmem_data    = head_valid ? entries[head_idx].data : '0;
  assign proc2Dmem_size    = DOUBLE;
  assign sb_count          = count;
  assign sb_empty          = !head_valid && !store_en;
  assign sb_almost_full    = (count >= CW'(SB_DEPTH - 1));

  store_buffer_fwd #(.SB_DEPTH(SB_DEPTH)) u_fwd (
    .entries    (entries),
    .head       (head_idx),
    .store_en   (store_en),
    .store_addr (store_addr),
    .store_data (store_data),
    .ld_addr    (ld_addr),
    .hit        (ld_hit),
    .data       (ld_data)
  );

  a_store_aligned: assert property (@(posedge clock) disable iff (!reset)
    store_en |-> (store_addr[2:0] == 3'b000));

  generate
    if (OVERFLOW_ASSERT) begin : g_overflow_check
      a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !drop);
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_retire_store_buffer.sv
// tb_retire_store_buffer: directed and randomized checks of retire_store_buffer against a queue model.
// Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_retire_store_buffer;
  import retire_store_buffer_pkg::*;

  localparam int DEPTH = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         store_en = 1'b0;
  logic [31:0]  store_addr = '0;
  logic [63:0]  store_data = '0;
  logic [3:0]   mem2proc_response = '0;
  logic [31:0]  ld_addr = '0;
  bus_command_t proc2Dmem_command;
  logic [31:0]  proc2Dmem_addr;
  logic [63:0]  proc2Dmem_data;
  mem_size_t    proc2Dmem_size;
  logic         ld_hit;
  logic [63:0]  ld_data;
  logic [3:0]   sb_count;
  logic         sb_empty, sb_almost_full, sb_overflow;

  int checks = 0;
  int fails  = 0;

  logic [31:0] q_addr [$];
  logic [63:0] q_data [$];
  bit          m_ovf = 1'b0;

  always #5 clock = ~clock;

  retire_store_buffer #(.SB_DEPTH(DEPTH), .OVERFLOW_ASSERT(1'b0)) dut (
    .clock             (clock),
    .reset             (reset),
    .store_en          (store_en),
    .store_addr        (store_addr),
    .store_data        (store_data),
    .mem2proc_response (mem2proc_response),
    .proc2Dmem_command (proc2Dmem_command),
    .proc2Dmem_addr    (proc2Dmem_addr),
    .proc2Dmem_data    (proc2Dmem_data),
    .proc2Dmem_size    (proc2Dmem_size),
    .ld_addr           (ld_addr),
    .ld_hit            (ld_hit),
    .ld_data           (ld_data),
    .sb_count          (sb_count),
    .sb_empty          (sb_empty),
    .sb_almost_full    (sb_almost_full),
    .sb_overflow       (sb_overflow)
  );

  // Reference: the buffer is a list of committed dwords, oldest first.
  task automatic model_update();
    int n;
    bit popping, do_push;
    n       = q_addr.size();
    popping = (n > 0) && (mem2proc_response != 4'h0);
    do_push = 1'b0;
    if (store_en) begin
      if (n > 0 && q_addr[n-1][31:3] == store_addr[31:3] && !(n == 1 && popping))
        q_data[n-1] = store_data;
      else if (n < DEPTH || popping)
        do_push = 1'b1;
      else
        m_ovf = 1'b1;
    end
    if (popping) begin
      void'(q_addr.pop_front());
      void'(q_data.pop_front());
    end
    if (do_push) begin
      q_addr.push_back({store_addr[31:3], 3'b000});
      q_data.push_back(store_data);
    end
  endtask

  function automatic void model_fwd(output bit h, output logic [63:0] d);
    h = 1'b0;
    d = '0;
    if (store_en && store_addr[31:3] == ld_addr[31:3]) begin
      h = 1'b1;
      d = store_data;
      return;
    end
    for (int i = q_addr.size() - 1; i >= 0; i--) begin
      if (q_addr[i][31:3] == ld_addr[31:3]) begin
        h = 1'b1;
        d = q_data[i];
        return;
      end
    end
  endfunction

  task automatic drive(input logic en, input logic [31:0] a, input logic [63:0] d,
                       input logic [3:0] r, input logic [31:0] ld);
    store_en          = en;
    store_addr        = a;
    store_data        = d;
    mem2proc_response = r;
    ld_addr           = ld;
    #1;
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h100);
    checks++; if (proc2Dmem_command !== BUS_NONE) begin fails++; $display("FAIL reset_cmd: got %0h expected %0h", proc2Dmem_command, BUS_NONE); end
    checks++; if (proc2Dmem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %0h expected 0", proc2Dmem_addr); end
    checks++; if (proc2Dmem_data !== 64'h0) begin fails++; $display("FAIL reset_data: got %0h expected 0", proc2Dmem_data); end
    checks++; if (proc2Dmem_size !== DOUBLE) begin fails++; $display("FAIL reset_size: got %0h expected %0h", proc2Dmem_size, DOUBLE); end
    checks++; if (ld_hit !== 1'b0 || ld_data !== 64'h0) begin fails++; $display("FAIL reset_fwd: got hit=%0b data=%0h expected hit=0 data=0", ld_hit, ld_data); end
    checks++; if (sb_count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d expected 0", sb_count); end
    checks++; if (sb_empty !== 1'b1 || sb_almost_full !== 1'b0 || sb_overflow !== 1'b0) begin
      fails++; $display("FAIL reset_flags: got empty=%0b af=%0b ovf=%0b expected 1 0 0", sb_empty, sb_almost_full, sb_overflow);
    end
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
  endtask

  task automatic test_drain_latency();
    drive(1'b1, 32'h100, 64'h11, 4'h0, 32'h0);
    checks++; if (sb_empty !== 1'b0) begin fails++; $display("FAIL latency_empty_push: got %0b expected 0", sb_empty); end
    checks++; if (proc2Dmem_command !== BUS_NONE) begin fails++; $display("FAIL latency_cmd_c0: got %0h expected %0h", proc2Dmem_command, BUS_NONE); end
    advance();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 32'h0, 64'h0, (c == 3) ? 4'h1 : 4'h0, 32'h0);
      checks++; if (proc2Dmem_command !== BUS_STORE) begin fails++; $display("FAIL latency_cmd_c%0d: got %0h expected %0h", c, proc2Dmem_command, BUS_STORE); end
      checks++; if (proc2Dmem_addr !== 32'h100 || proc2Dmem_data !== 64'h11) begin
        fails++; $display("FAIL latency_req_c%0d: got %0h/%0h expected 100/11", c, proc2Dmem_addr, proc2Dmem_data);
      end
      checks++; if (sb_count !== 4'd1) begin fails++; $display("FAIL latency_count_c%0d: got %0d expected 1", c, sb_count); end
      advance();
    end
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd0 || sb_empty !== 1'b1 || proc2Dmem_command !== BUS_NONE) begin
      fails++; $display("FAIL latency_after: got count=%0d empty=%0b cmd=%0h expected 0 1 0", sb_count, sb_empty, proc2Dmem_command);
    end
  endtask

  task automatic test_coalesce();
    drive(1'b1, 32'h200, 64'hAA, 4'h0, 32'h0); advance();
    drive(1'b1, 32'h200, 64'hBB, 4'h0, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd1) begin fails++; $display("FAIL coalesce_count: got %0d expected 1", sb_count); end
    checks++; if (proc2Dmem_addr !== 32'h200 || proc2Dmem_data !== 64'hBB) begin
      fails++; $display("FAIL coalesce_head: got %0h/%0h expected 200/bb", proc2Dmem_addr, proc2Dmem_data);
    end
    drive(1'b0, 32'h0, 64'h0, 4'h1, 32'h0); advance();
    drive(1'b1, 32'h200, 64'hAA, 4'h0, 32'h0); advance();
    drive(1'b1, 32'h200, 64'hBB, 4'h3, 32'h0);
    checks++; if (proc2Dmem_data !== 64'hAA) begin fails++; $display("FAIL coalesce_accepted_head: got %0h expected aa", proc2Dmem_data); end
    advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd1 || proc2Dmem_addr !== 32'h200 || proc2Dmem_data !== 64'hBB) begin
      fails++; $display("FAIL coalesce_alloc: got count=%0d %0h/%0h expected 1 200/bb", sb_count, proc2Dmem_addr, proc2Dmem_data);
    end
    drive(1'b0, 32'h0, 64'h0, 4'h1, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd0) begin fails++; $display("FAIL coalesce_drained: got %0d expected 0", sb_count); end
  endtask

  task automatic test_full_overflow();
    logic [63:0] exp_d;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(8 * i), 64'hF0 + 64'(i), 4'h0, 32'h0);
      advance();
      drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
      checks++; if (sb_count !== 4'(i + 1) || sb_almost_full !== (i + 1 >= DEPTH - 1)) begin
        fails++; $display("FAIL fill_%0d: got count=%0d af=%0b expected %0d %0b", i, sb_count, sb_almost_full, i + 1, (i + 1 >= DEPTH - 1));
      end
    end
    drive(1'b1, 32'h40, 64'h99, 4'h1, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd8 || sb_overflow !== 1'b0 || proc2Dmem_addr !== 32'h8) begin
      fails++; $display("FAIL full_push_pop: got count=%0d ovf=%0b head=%0h expected 8 0 8", sb_count, sb_overflow, proc2Dmem_addr);
    end
    drive(1'b1, 32'h48, 64'h9A, 4'h0, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd8 || sb_overflow !== 1'b1) begin
      fails++; $display("FAIL full_overflow: got count=%0d ovf=%0b expected 8 1", sb_count, sb_overflow);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 32'h0, 64'h0, 4'h1, 32'h0);
      exp_d = (i < DEPTH - 1) ? 64'hF1 + 64'(i) : 64'h99;
      checks++; if (proc2Dmem_addr !== 32'(8 * (i + 1)) || proc2Dmem_data !== exp_d) begin
        fails++; $display("FAIL full_drain_%0d: got %0h/%0h expected %0h/%0h", i, proc2Dmem_addr, proc2Dmem_data, 8 * (i + 1), exp_d);
      end
      advance();
    end
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd0 || sb_overflow !== 1'b1) begin
      fails++; $display("FAIL full_after: got count=%0d ovf=%0b expected 0 1", sb_count, sb_overflow);
    end
  endtask

  task automatic test_forwarding();
    drive(1'b1, 32'h308, 64'h5, 4'h0, 32'h0); advance();
    drive(1'b1, 32'h300, 64'h1, 4'h0, 32'h0); advance();
    drive(1'b1, 32'h300, 64'h2, 4'h0, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h304);
    checks++; if (sb_count !== 4'd2 || proc2Dmem_addr !== 32'h308) begin
      fails++; $display("FAIL fwd_setup: got count=%0d head=%0h expected 2 308", sb_count, proc2Dmem_addr);
    end
    checks++; if (ld_hit !== 1'b1 || ld_data !== 64'h2) begin fails++; $display("FAIL fwd_buffered: got hit=%0b data=%0h expected 1 2", ld_hit, ld_data); end
    drive(1'b1, 32'h300, 64'h3, 4'h0, 32'h304);
    checks++; if (ld_hit !== 1'b1 || ld_data !== 64'h3) begin fails++; $display("FAIL fwd_incoming: got hit=%0b data=%0h expected 1 3", ld_hit, ld_data); end
    advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h400);
    checks++; if (ld_hit !== 1'b0 || ld_data !== 64'h0) begin fails++; $display("FAIL fwd_miss: got hit=%0b data=%0h expected 0 0", ld_hit, ld_data); end
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h30C);
    checks++; if (ld_hit !== 1'b1 || ld_data !== 64'h5 || sb_count !== 4'd2) begin
      fails++; $display("FAIL fwd_head: got hit=%0b data=%0h count=%0d expected 1 5 2", ld_hit, ld_data, sb_count);
    end
    drive(1'b0, 32'h0, 64'h0, 4'h1, 32'h0); advance(); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd0) begin fails++; $display("FAIL fwd_drained: got %0d expected 0", sb_count); end
  endtask

  task automatic test_random_stream();
    int          pushed, cyc;
    logic        en;
    logic [31:0] a, prev, ld;
    logic [63:0] d;
    logic [3:0]  r;
    bit          eh;
    logic [63:0] ed;
    pushed = 0;
    cyc    = 0;
    prev   = 32'h1000;
    while ((pushed < 20 || q_addr.size() > 0) && cyc < 400) begin
      en = (pushed < 20) && (q_addr.size() < DEPTH - 1) && ($urandom_range(0, 2) != 0);
      a  = (pushed > 0 && $urandom_range(0, 7) == 0) ? prev : 32'h1000 + 32'(8 * $urandom_range(0, 31));
      d  = {$urandom, $urandom};
      r  = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      ld = 32'h1000 + 32'(8 * $urandom_range(0, 31)) + 32'($urandom_range(0, 7));
      drive(en, a, d, r, ld);
      if (en) begin
        pushed++;
        prev = a;
      end
      model_fwd(eh, ed);
      checks++; if (proc2Dmem_command !== ((q_addr.size() > 0) ? BUS_STORE : BUS_NONE)) begin
        fails++; $display("FAIL rand_cmd cyc %0d: got %0h expected size %0d", cyc, proc2Dmem_command, q_addr.size());
      end
      if (q_addr.size() > 0) begin
        checks++; if (proc2Dmem_addr !== q_addr[0] || proc2Dmem_data !== q_data[0]) begin
          fails++; $display("FAIL rand_req cyc %0d: got %0h/%0h expected %0h/%0h", cyc, proc2Dmem_addr, proc2Dmem_data, q_addr[0], q_data[0]);
        end
      end
      checks++; if (sb_count !== 4'(q_addr.size())) begin fails++; $display("FAIL rand_count cyc %0d: got %0d expected %0d", cyc, sb_count, q_addr.size()); end
      checks++; if (ld_hit !== eh || ld_data !== ed) begin
        fails++; $display("FAIL rand_fwd cyc %0d: got %0b/%0h expected %0b/%0h", cyc, ld_hit, ld_data, eh, ed);
      end
      checks++; if (sb_overflow !== m_ovf) begin fails++; $display("FAIL rand_ovf cyc %0d: got %0b expected %0b", cyc, sb_overflow, m_ovf); end
      advance();
      cyc++;
    end
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (q_addr.size() != 0 || pushed < 20 || sb_count !== 4'd0) begin
      fails++; $display("FAIL rand_budget: got count=%0d pushed=%0d expected 0 20 within 400 cycles", sb_count, pushed);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h500, 64'h50, 4'h0, 32'h0); advance();
    drive(1'b1, 32'h508, 64'h51, 4'h0, 32'h0); advance();
    drive(1'b1, 32'h510, 64'h52, 4'h0, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h508);
    checks++; if (sb_count !== 4'd3 || ld_hit !== 1'b1 || sb_overflow !== m_ovf) begin
      fails++; $display("FAIL areset_pre: got count=%0d hit=%0b ovf=%0b expected 3 1 %0b", sb_count, ld_hit, sb_overflow, m_ovf);
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (proc2Dmem_command !== BUS_NONE || proc2Dmem_addr !== 32'h0 || proc2Dmem_data !== 64'h0) begin
      fails++; $display("FAIL areset_bus: got %0h %0h/%0h expected 0 0/0", proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data);
    end
    checks++; if (sb_count !== 4'd0 || sb_overflow !== 1'b0 || ld_hit !== 1'b0 || sb_empty !== 1'b1) begin
      fails++; $display("FAIL areset_state: got count=%0d ovf=%0b hit=%0b empty=%0b expected 0 0 0 1", sb_count, sb_overflow, ld_hit, sb_empty);
    end
    q_addr.delete();
    q_data.delete();
    m_ovf = 1'b0;
    @(posedge clock);
    #1 reset = 1'b1;
    drive(1'b1, 32'h600, 64'h77, 4'h0, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_count !== 4'd1 || proc2Dmem_command !== BUS_STORE || proc2Dmem_addr !== 32'h600 || proc2Dmem_data !== 64'h77) begin
      fails++; $display("FAIL areset_after: got count=%0d cmd=%0h %0h/%0h expected 1 2 600/77", sb_count, proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data);
    end
    drive(1'b0, 32'h0, 64'h0, 4'h1, 32'h0); advance();
    drive(1'b0, 32'h0, 64'h0, 4'h0, 32'h0);
    checks++; if (sb_empty !== 1'b1) begin fails++; $display("FAIL areset_drain: got empty=%0b expected 1", sb_empty); end
  endtask

  initial begin
    test_reset();
    test_drain_latency();
    test_coalesce();
    test_full_overflow();
    test_forwarding();
    test_random_stream();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks done", checks);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
